// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: one word per accepted start, runtime
// CPOL/CPHA/bit order, multiple chip selects, programmable CS setup/hold/gap.
module spi_master_param #(
  parameter int DATA_W       = 24,
  parameter int CLK_DIV      = 16,
  parameter int NUM_CS       = 1,
  parameter int CS_SETUP_CYC = 8,
  parameter int CS_HOLD_CYC  = 8,
  parameter int CS_GAP_CYC   = 16,
  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [NUM_CS-1:0] cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              new_data
);

  localparam int HALF    = CLK_DIV / 2;
  localparam int HC_W    = $clog2(CLK_DIV) - 1;
  localparam int BC_W    = $clog2(DATA_W + 1);
  localparam int PH_MAX0 = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int PH_MAX  = (PH_MAX0 > CS_GAP_CYC) ? PH_MAX0 : CS_GAP_CYC;
  localparam int PH_W    = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, GAP} state_t;

  state_t            state, state_next;
  logic [PH_W-1:0]   ph_cnt;
  logic [HC_W-1:0]   half_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, tx_shift, rx_shift;
  logic [SEL_W-1:0]  sel_q, sel_now;
  logic              cpol_q, cpha_q, lsb_q;
  logic              accept, sck_toggle, lead_edge, trail_edge, last_trail;
  logic              tx_next_bit, cs_active_next;
  logic [NUM_CS-1:0] cs_n_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Edge decode: a toggle away from the idle level is the leading edge.
  always_comb begin
    accept      = (state == IDLE) && start && (32'(cs_sel) < NUM_CS);
    sck_toggle  = (state == TRANSFER) && (half_cnt == HC_W'(HALF - 1));
    lead_edge   = sck_toggle && (sck == cpol_q);
    trail_edge  = sck_toggle && (sck != cpol_q);
    last_trail  = trail_edge && (bit_cnt == BC_W'(DATA_W - 1));
    tx_shift    = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
    tx_next_bit = lsb_q ? tx_sr[1] : tx_sr[DATA_W-2];
    rx_shift    = lsb_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = SETUP;
      SETUP:    if (ph_cnt == PH_W'(CS_SETUP_CYC - 1)) state_next = TRANSFER;
      TRANSFER: if (last_trail) state_next = HOLD;
      HOLD:     if (ph_cnt == PH_W'(CS_HOLD_CYC - 1)) state_next = GAP;
      GAP:      if (ph_cnt == PH_W'(CS_GAP_CYC - 1)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    sel_now        = (state == IDLE) ? cs_sel : sel_q;
    cs_active_next = (state_next == SETUP) || (state_next == TRANSFER) || (state_next == HOLD);
    cs_n_next      = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_active_next && (SEL_W'(i) == sel_now)) cs_n_next[i] = 1'b0;
    end
  end

  // Outputs are registered from the next state so cs_n and busy are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi     <= 1'b0;
      sck      <= 1'b0;
      cs_n     <= '1;
      data_out <= '0;
      busy     <= 1'b0;
      new_data <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      sel_q    <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      ph_cnt   <= '0;
      half_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      cs_n     <= cs_n_next;
      busy     <= (state_next != IDLE);
      new_data <= (state == HOLD) && (state_next == GAP);

      if (state_next != state) ph_cnt <= '0;
      else if ((state == SETUP) || (state == HOLD) || (state == GAP)) ph_cnt <= ph_cnt + PH_W'(1);

      if (accept) begin
        tx_sr    <= data_in;
        sel_q    <= cs_sel;
        cpol_q   <= cpol;
        cpha_q   <= cpha;
        lsb_q    <= lsb_first;
        sck      <= cpol;
        mosi     <= lsb_first ? data_in[0] : data_in[DATA_W-1];
        half_cnt <= '0;
        bit_cnt  <= '0;
      end

      if (state == HOLD && state_next == GAP) data_out <= rx_sr;

      if (state == TRANSFER) begin
        half_cnt <= sck_toggle ? '0 : half_cnt + HC_W'(1);
        if (sck_toggle) sck <= ~sck;
        // CPHA=1 already shows bit 0 since SETUP, so its first leading edge does not shift.
        if (lead_edge) begin
          if (!cpha_q) rx_sr <= rx_shift;
          else if (bit_cnt != '0) begin
            mosi  <= tx_next_bit;
            tx_sr <= tx_shift;
          end
        end
        if (trail_edge) begin
          bit_cnt <= bit_cnt + BC_W'(1);
          if (cpha_q) rx_sr <= rx_shift;
          else if (!last_trail) begin
            mosi  <= tx_next_bit;
            tx_sr <= tx_shift;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: a default-parameter instance plus a
// small 8-bit / 5-chip-select instance sharing clock and reset.
module tb_spi_master_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start, cs_sel, cpol, cpha, lsb_first, miso, mosi, sck, busy, new_data;
  logic [23:0] data_in, data_out;
  logic [0:0]  cs_n;

  logic        start2, mosi2, sck2, busy2, new_data2;
  logic [7:0]  data_in2, data_out2;
  logic [2:0]  cs_sel2;
  logic [4:0]  cs_n2;

  logic        mon_en, slave_en, slave_bit, prev_cs, prev_sck, prev_mosi;
  logic [23:0] slave_word;
  int          busy_cnt, cs_low_cnt, nd_cnt, nd_coinc, sck_rise_cnt, bad_mosi, rise_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  assign miso = slave_en ? slave_bit : mosi;

  spi_master_param dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .miso(miso), .mosi(mosi),
    .sck(sck), .cs_n(cs_n), .data_out(data_out), .busy(busy), .new_data(new_data)
  );

  spi_master_param #(
    .DATA_W(8), .CLK_DIV(4), .NUM_CS(5), .CS_SETUP_CYC(2), .CS_HOLD_CYC(2), .CS_GAP_CYC(3)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .data_in(data_in2), .cs_sel(cs_sel2),
    .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .miso(mosi2), .mosi(mosi2),
    .sck(sck2), .cs_n(cs_n2), .data_out(data_out2), .busy(busy2), .new_data(new_data2)
  );

  // Mode-3 slave: presents the next bit after each trailing (rising) sck edge.
  always_comb begin
    slave_bit = 1'b0;
    if (rise_cnt < 24) slave_bit = slave_word[5'(23 - rise_cnt)];
  end

  always @(negedge clk) begin
    prev_cs   <= cs_n[0];
    prev_sck  <= sck;
    prev_mosi <= mosi;
    if (!mon_en) begin
      busy_cnt <= 0; cs_low_cnt <= 0; nd_cnt <= 0; nd_coinc <= 0;
      sck_rise_cnt <= 0; bad_mosi <= 0; rise_cnt <= 0;
    end else begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (!cs_n[0]) cs_low_cnt <= cs_low_cnt + 1;
      if (new_data) begin
        nd_cnt <= nd_cnt + 1;
        if (cs_n[0] && !prev_cs) nd_coinc <= nd_coinc + 1;
      end
      if (!cs_n[0] && !prev_cs && !prev_sck && sck) begin
        sck_rise_cnt <= sck_rise_cnt + 1;
        if (slave_en) rise_cnt <= rise_cnt + 1;
      end
      if (!cs_n[0] && !prev_cs && (mosi != prev_mosi) && !(prev_sck && !sck))
        bad_mosi <= bad_mosi + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Requests one transfer on slave 0 and returns in the first SETUP cycle.
  task automatic apply_stimulus(input logic [23:0] d, input logic p, input logic h, input logic l);
    data_in = d; cpol = p; cpha = h; lsb_first = l; cs_sel = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (busy && cyc < 1000) begin
      tick();
      cyc++;
    end
    check_output(tag, {63'd0, busy}, 64'd0);
  endtask

  int cyc, gap_cnt, n, cnt2, idle_nd;
  logic saw_idle;
  logic [23:0] idle_data;

  initial begin
    start = 0; data_in = '0; cs_sel = 0; cpol = 0; cpha = 0; lsb_first = 0;
    start2 = 0; data_in2 = '0; cs_sel2 = '0;
    mon_en = 0; slave_en = 0; slave_word = 24'h123456;

    #1 rst = 1'b1;
    #1;
    check_output("rst_mosi", {63'd0, mosi}, 64'd0);
    check_output("rst_sck", {63'd0, sck}, 64'd0);
    check_output("rst_cs_n", {63'd0, cs_n}, 64'd1);
    check_output("rst_data_out", {40'd0, data_out}, 64'd0);
    check_output("rst_busy", {63'd0, busy}, 64'd0);
    check_output("rst_new_data", {63'd0, new_data}, 64'd0);
    check_output("rst_cs_n2", {59'd0, cs_n2}, 64'h1F);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    $display("[TB] mode 0, msb first, loopback 0xA5C3F0");
    mon_en = 1;
    apply_stimulus(24'hA5C3F0, 1'b0, 1'b0, 1'b0);
    check_output("m0_setup_busy", {63'd0, busy}, 64'd1);
    check_output("m0_setup_cs_n", {63'd0, cs_n}, 64'd0);
    check_output("m0_setup_mosi", {63'd0, mosi}, 64'd1);
    check_output("m0_setup_sck", {63'd0, sck}, 64'd0);
    wait_idle("m0_idle_timeout", cyc);
    check_output("m0_busy_cycles_loop", 64'(cyc), 64'd416);
    check_output("m0_busy_cycles", 64'(busy_cnt), 64'd416);
    check_output("m0_cs_low_cycles", 64'(cs_low_cnt), 64'd400);
    check_output("m0_sck_rises", 64'(sck_rise_cnt), 64'd24);
    check_output("m0_new_data_pulses", 64'(nd_cnt), 64'd1);
    check_output("m0_new_data_at_cs_rise", 64'(nd_coinc), 64'd1);
    check_output("m0_data_out", {40'd0, data_out}, 64'hA5C3F0);
    mon_en = 0;
    tick();

    $display("[TB] mode 3, slave returns 0x123456");
    mon_en = 1; slave_en = 1;
    apply_stimulus(24'hC3C3C3, 1'b1, 1'b1, 1'b0);
    check_output("m3_setup_sck", {63'd0, sck}, 64'd1);
    check_output("m3_setup_mosi", {63'd0, mosi}, 64'd1);
    repeat (391) tick();
    check_output("m3_last_xfer_sck", {63'd0, sck}, 64'd0);
    tick();
    check_output("m3_hold_sck", {63'd0, sck}, 64'd1);
    check_output("m3_hold_cs_n", {63'd0, cs_n}, 64'd0);
    wait_idle("m3_idle_timeout", cyc);
    check_output("m3_data_out", {40'd0, data_out}, 64'h123456);
    check_output("m3_idle_sck", {63'd0, sck}, 64'd1);
    check_output("m3_mosi_only_on_fall", 64'(bad_mosi), 64'd0);
    mon_en = 0; slave_en = 0;
    tick();

    $display("[TB] lsb first, loopback 0x000001");
    apply_stimulus(24'h000001, 1'b0, 1'b0, 1'b1);
    check_output("lsb_first_mosi", {63'd0, mosi}, 64'd1);
    wait_idle("lsb_idle_timeout", cyc);
    check_output("lsb_data_out", {40'd0, data_out}, 64'h000001);

    $display("[TB] 8-bit, 5 chip selects");
    cs_sel2 = 3'd5; data_in2 = 8'h81; start2 = 1;
    tick();
    start2 = 0;
    check_output("cs5_ignored_busy", {63'd0, busy2}, 64'd0);
    check_output("cs5_ignored_cs_n", {59'd0, cs_n2}, 64'h1F);
    cs_sel2 = 3'd7; start2 = 1;
    tick();
    start2 = 0;
    check_output("cs7_ignored_busy", {63'd0, busy2}, 64'd0);
    check_output("cs7_ignored_cs_n", {59'd0, cs_n2}, 64'h1F);
    cs_sel2 = 3'd2; start2 = 1;
    tick();
    start2 = 0; cs_sel2 = 3'd0; data_in2 = 8'h00;
    check_output("cs2_only_cs_n2_low", {59'd0, cs_n2}, 64'h1B);
    cnt2 = 1; n = 0;
    while (busy2 && n < 100) begin
      tick();
      n++;
      if (busy2) cnt2++;
    end
    check_output("w8_busy_cycles", 64'(cnt2), 64'd39);
    check_output("w8_data_out", {56'd0, data_out2}, 64'h81);

    $display("[TB] start held through GAP");
    mon_en = 1;
    apply_stimulus(24'h5A5A5A, 1'b0, 1'b0, 1'b0);
    repeat (100) tick();
    data_in = 24'hFFFFFF; cpol = 1; lsb_first = 1; start = 1;
    n = 0;
    while (!cs_n[0] && n < 500) begin
      tick();
      n++;
    end
    gap_cnt = 1; saw_idle = 0; idle_data = '0; idle_nd = 0; n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (!cs_n[0]) break;
      gap_cnt++;
      if (!busy) begin
        saw_idle = 1; idle_data = data_out; idle_nd = nd_cnt;
      end
    end
    start = 0;
    // High window is the GAP cycles plus the single IDLE cycle that accepts.
    check_output("b2b_cs_high_cycles", 64'(gap_cnt), 64'd17);
    check_output("b2b_saw_idle", {63'd0, saw_idle}, 64'd1);
    check_output("b2b_first_word", {40'd0, idle_data}, 64'h5A5A5A);
    check_output("b2b_one_pulse", 64'(idle_nd), 64'd1);
    mon_en = 0;
    wait_idle("b2b_idle_timeout", cyc);
    check_output("b2b_second_word", {40'd0, data_out}, 64'hFFFFFF);
    check_output("b2b_idle_sck", {63'd0, sck}, 64'd1);
    tick();

    $display("[TB] reset mid-transfer");
    mon_en = 1;
    apply_stimulus(24'h3C3C3C, 1'b1, 1'b0, 1'b0);
    repeat (200) tick();
    check_output("mid_xfer_sck", {63'd0, sck}, 64'd1);
    rst = 1'b1;
    #1;
    check_output("arst_cs_n", {63'd0, cs_n}, 64'd1);
    check_output("arst_sck", {63'd0, sck}, 64'd0);
    check_output("arst_busy", {63'd0, busy}, 64'd0);
    check_output("arst_data_out", {40'd0, data_out}, 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    check_output("arst_no_new_data", 64'(nd_cnt), 64'd0);
    mon_en = 0;
    apply_stimulus(24'h3C3C3C, 1'b0, 1'b0, 1'b0);
    wait_idle("post_rst_idle_timeout", cyc);
    check_output("post_rst_data_out", {40'd0, data_out}, 64'h3C3C3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
